// File: rtl/processing_pkg.sv
// Shared types and constants for the pixel processing stage:
// coordinate width, edge-list layout and the row scheduler state type.
package processing_pkg;

   localparam int COORD_W   = 11;
   localparam int N_EDGES   = 30;
   localparam int IDX_W     = 5;
   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;

   // Entry k of the list occupies bits [k*COORD_W +: COORD_W].
   typedef logic [N_EDGES-1:0][COORD_W-1:0] edge_list_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      SCAN  = 2'd2,
      EMIT  = 2'd3
   } sched_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/edge_list_scanner.sv
// Serial reducer for a zero-terminated edge list: one entry per cycle,
// producing count, first x, last x and widest consecutive gap.
module edge_list_scanner
   import processing_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_i,
   input  edge_list_t         list_i,
   output logic               done_o,
   output logic [IDX_W-1:0]   count_o,
   output logic [COORD_W-1:0] first_o,
   output logic [COORD_W-1:0] last_o,
   output logic [COORD_W-1:0] gap_o
);

   logic               active_q;
   logic [IDX_W-1:0]   k_q;
   logic [COORD_W-1:0] prev_q;
   logic [COORD_W-1:0] first_q;
   logic [COORD_W-1:0] gap_q;

   logic [COORD_W-1:0] cur_s;
   logic [COORD_W-1:0] diff_s;
   logic               zero_s;
   logic               at_end_s;

   // Results are presented combinationally on the terminating cycle so the
   // caller can register them on the same edge that ends the scan.
   always_comb begin
      cur_s    = list_i[k_q];
      zero_s   = (cur_s == {COORD_W{1'b0}});
      at_end_s = (k_q == IDX_W'(N_EDGES - 1));
      diff_s   = cur_s - prev_q;
      done_o   = active_q && (zero_s || at_end_s);

      if (zero_s) begin
         count_o = k_q;
         last_o  = (k_q == {IDX_W{1'b0}}) ? {COORD_W{1'b0}} : prev_q;
      end else begin
         count_o = IDX_W'(N_EDGES);
         last_o  = cur_s;
      end

      if (k_q == {IDX_W{1'b0}}) begin
         first_o = cur_s;
      end else begin
         first_o = first_q;
      end

      if ((k_q != {IDX_W{1'b0}}) && !zero_s && (diff_s > gap_q)) begin
         gap_o = diff_s;
      end else begin
         gap_o = gap_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_q <= 1'b0;
         k_q      <= {IDX_W{1'b0}};
         prev_q   <= {COORD_W{1'b0}};
         first_q  <= {COORD_W{1'b0}};
         gap_q    <= {COORD_W{1'b0}};
      end else if (start_i) begin
         active_q <= 1'b1;
         k_q      <= {IDX_W{1'b0}};
         prev_q   <= {COORD_W{1'b0}};
         first_q  <= {COORD_W{1'b0}};
         gap_q    <= {COORD_W{1'b0}};
      end else if (active_q) begin
         if (done_o) begin
            active_q <= 1'b0;
         end else begin
            k_q     <= k_q + 5'd1;
            prev_q  <= cur_s;
            first_q <= first_o;
            gap_q   <= gap_o;
         end
      end
   end

endmodule

// File: rtl/edge_row_scheduler.sv
// Edge-measurement row controller: per frame it snapshots the edge list,
// reduces it serially and offers the summary on a valid/ready port.
// Optional ROW_SWEEP_EN: sweep edge_row ROW_MIN..ROW_MAX; otherwise it stays at ROW_MIN.
module edge_row_scheduler
   import processing_pkg::*;
#(
   parameter int IMG_W    = IMG_W_DEF,
   parameter int IMG_H    = IMG_H_DEF,
   parameter int ROW_MIN  = 200,
   parameter int ROW_MAX  = 400,
   parameter int ROW_STEP = 20
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               sop,
   input  logic               in_valid,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  edge_list_t         measured_list,
   output logic [COORD_W-1:0] edge_row,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [COORD_W-1:0] res_row,
   output logic [IDX_W-1:0]   res_count,
   output logic [COORD_W-1:0] res_first,
   output logic [COORD_W-1:0] res_last,
   output logic [COORD_W-1:0] res_max_gap,
   output logic [7:0]         skipped_frames,
   output logic               busy
);

`ifdef ROW_SWEEP_EN
   localparam bit SWEEP_EN = 1'b1;
`else
   localparam bit SWEEP_EN = 1'b0;
`endif

   localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(IMG_H - 1);
   localparam logic [COORD_W-1:0] ROW_MIN_C = COORD_W'(ROW_MIN);
   localparam logic [COORD_W:0]   ROW_MAX_C = (COORD_W+1)'(ROW_MAX);
   localparam logic [COORD_W:0]   ROW_STP_C = (COORD_W+1)'(ROW_STEP);

   sched_state_t       state_q, state_d;
   logic [COORD_W-1:0] row_q, row_d;
   edge_list_t         snap_q, snap_d;
   logic               res_valid_q, res_valid_d;
   logic [COORD_W-1:0] res_row_q, res_row_d;
   logic [IDX_W-1:0]   res_count_q, res_count_d;
   logic [COORD_W-1:0] res_first_q, res_first_d;
   logic [COORD_W-1:0] res_last_q, res_last_d;
   logic [COORD_W-1:0] res_gap_q, res_gap_d;
   logic [7:0]         skip_q, skip_d;
   logic               busy_q, busy_d;

   logic               start_s;
   logic               eof_s;
   logic [COORD_W:0]   row_sum_s;
   logic [COORD_W-1:0] row_next_s;
   logic               scan_done_s;
   logic [IDX_W-1:0]   scan_count_s;
   logic [COORD_W-1:0] scan_first_s, scan_last_s, scan_gap_s;

   edge_list_scanner u_scanner (
      .clk     (clk),
      .reset_n (reset_n),
      .start_i (start_s),
      .list_i  (snap_q),
      .done_o  (scan_done_s),
      .count_o (scan_count_s),
      .first_o (scan_first_s),
      .last_o  (scan_last_s),
      .gap_o   (scan_gap_s)
   );

   // Row to use after a handshake; wraps back to ROW_MIN once past ROW_MAX.
   always_comb begin
      row_sum_s = {1'b0, row_q} + ROW_STP_C;
      if (!SWEEP_EN) begin
         row_next_s = ROW_MIN_C;
      end else if (row_sum_s > ROW_MAX_C) begin
         row_next_s = ROW_MIN_C;
      end else begin
         row_next_s = row_sum_s[COORD_W-1:0];
      end
   end

   always_comb begin
      eof_s       = in_valid && (x == X_LAST) && (y == Y_LAST);
      state_d     = state_q;
      row_d       = row_q;
      snap_d      = snap_q;
      res_valid_d = res_valid_q;
      res_row_d   = res_row_q;
      res_count_d = res_count_q;
      res_first_d = res_first_q;
      res_last_d  = res_last_q;
      res_gap_d   = res_gap_q;
      start_s     = 1'b0;

      // Any sop outside IDLE is dropped, including one on the handshake cycle.
      if (sop && (state_q != IDLE)) begin
         skip_d = sat_inc8(skip_q);
      end else begin
         skip_d = skip_q;
      end

      case (state_q)
         IDLE: begin
            if (sop && enable) begin
               state_d = FRAME;
            end else begin
               state_d = IDLE;
            end
         end
         FRAME: begin
            if (eof_s) begin
               snap_d  = measured_list;
               start_s = 1'b1;
               state_d = SCAN;
            end else begin
               state_d = FRAME;
            end
         end
         SCAN: begin
            if (scan_done_s) begin
               res_valid_d = 1'b1;
               res_row_d   = row_q;
               res_count_d = scan_count_s;
               res_first_d = scan_first_s;
               res_last_d  = scan_last_s;
               res_gap_d   = scan_gap_s;
               state_d     = EMIT;
            end else begin
               state_d = SCAN;
            end
         end
         EMIT: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               row_d       = row_next_s;
               state_d     = IDLE;
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         row_q       <= ROW_MIN_C;
         snap_q      <= '0;
         res_valid_q <= 1'b0;
         res_row_q   <= {COORD_W{1'b0}};
         res_count_q <= {IDX_W{1'b0}};
         res_first_q <= {COORD_W{1'b0}};
         res_last_q  <= {COORD_W{1'b0}};
         res_gap_q   <= {COORD_W{1'b0}};
         skip_q      <= 8'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         snap_q      <= snap_d;
         res_valid_q <= res_valid_d;
         res_row_q   <= res_row_d;
         res_count_q <= res_count_d;
         res_first_q <= res_first_d;
         res_last_q  <= res_last_d;
         res_gap_q   <= res_gap_d;
         skip_q      <= skip_d;
         busy_q      <= busy_d;
      end
   end

   assign edge_row       = row_q;
   assign res_valid      = res_valid_q;
   assign res_row        = res_row_q;
   assign res_count      = res_count_q;
   assign res_first      = res_first_q;
   assign res_last       = res_last_q;
   assign res_max_gap    = res_gap_q;
   assign skipped_frames = skip_q;
   assign busy           = busy_q;

endmodule
